// File: rtl/mac_serial_accumulate.sv
// Shift-and-add unsigned MAC: one op per WIDTH+2 cycles, acc updates WIDTH+1 edges after the handshake.
// in_ready only in IDLE (no queuing); define MAC_SATURATE_EN to clamp acc on carry-out instead of wrapping.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);
  logic [W:0] carry;

  assign carry[0] = 1'b0;
  assign co_o     = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end
endmodule

module mac_serial_accumulate #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overflow
);
  typedef enum logic [1:0] {IDLE, MULT, ACCUM} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   out_vld_q, out_vld_d;

  // One adder serves both phases: partial-product sums in MULT, accumulation in ACCUM.
  logic [ACC_WIDTH-1:0]   add_a, add_b, add_sum;
  logic                   add_co;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == ACCUM) begin
      add_a = clear ? '0 : acc_q;
      add_b = ACC_WIDTH'(prod_q);
    end else begin
      add_a = ACC_WIDTH'(prod_q);
      add_b = mplier_q[0] ? ACC_WIDTH'(mcand_q) : '0;
    end
  end

  ripple_adder #(.W(ACC_WIDTH)) u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum),
    .co_o  (add_co)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;

    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = (2*WIDTH)'(a);
          mplier_d = b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        prod_d   = add_sum[2*WIDTH-1:0];
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = ACCUM;
      end
      ACCUM: begin
`ifdef MAC_SATURATE_EN
        acc_d = add_co ? '1 : add_sum;
`else
        acc_d = add_sum;
`endif
        // With clear, add_a is zero so add_co is zero and overflow ends up cleared.
        ovf_d     = (clear ? 1'b0 : ovf_q) | add_co;
        out_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign acc       = acc_q;
  assign overflow  = ovf_q;
  assign out_valid = out_vld_q;

endmodule

// File: tb/tb_mac_serial_accumulate.sv
// Scoreboard bench for mac_serial_accumulate; honours MAC_SATURATE_EN like the design.
module tb_mac_serial_accumulate;
  localparam int W  = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, busy, overflow;
  logic [AW-1:0] acc;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] m_acc = '0;
  logic          m_ovf = 1'b0;

  mac_serial_accumulate #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clear     (clear),
    .acc       (acc),
    .out_valid (out_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_acc", 32'(acc), 32'(e.acc));
        check("sb_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  function automatic void model_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit clr);
    logic [AW:0] s;
    exp_t        e;
    s = (clr ? '0 : {1'b0, m_acc}) + ((AW+1)'(av) * (AW+1)'(bv));
    m_ovf = (clr ? 1'b0 : m_ovf) | s[AW];
    m_acc = s[AW-1:0];
`ifdef MAC_SATURATE_EN
    if (s[AW]) m_acc = '1;
`endif
    e.acc = m_acc;
    e.ovf = m_ovf;
    sb_q.push_back(e);
  endfunction

  // Called and returns at a falling edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold, input bit clr_acc);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
    model_op(av, bv, clr_acc);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    check("in_ready_low", 32'(in_ready), 32'd0);
    check("busy_high", 32'(busy), 32'd1);
    if (!hold) in_valid = 1'b0;
    repeat (W) @(negedge clk);
    check("no_early_out_valid", 32'(out_valid), 32'd0);
    if (clr_acc) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("busy_low", 32'(busy), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
    check("clear_acc", 32'(acc), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd3, 8'd5, 1'b0, 1'b0);
    check("acc_3x5", 32'(acc), 32'd15);
    do_op(8'd255, 8'd255, 1'b1, 1'b0);
    check("acc_plus_65025", 32'(acc), 32'd65040);
    check("ovf_after_65040", 32'(overflow), 32'd0);

    do_clear();
    for (int i = 0; i < 16; i++) do_op(8'd255, 8'd255, 1'b0, 1'b0);
    check("acc_16_ops", 32'(acc), 32'd1040400);
    check("ovf_16_ops", 32'(overflow), 32'd0);
    do_op(8'd255, 8'd255, 1'b0, 1'b0);
`ifdef MAC_SATURATE_EN
    check("acc_17_ops", 32'(acc), 32'd1048575);
`else
    check("acc_17_ops", 32'(acc), 32'd56849);
`endif
    check("ovf_17_ops", 32'(overflow), 32'd1);

    do_clear();
    do_op(8'd10, 8'd10, 1'b0, 1'b0);
    check("acc_100", 32'(acc), 32'd100);
    do_op(8'd4, 8'd6, 1'b0, 1'b1);
    check("acc_clear_on_accum", 32'(acc), 32'd24);
    check("ovf_clear_on_accum", 32'(overflow), 32'd0);

    do_op(8'd0, 8'd200, 1'b0, 1'b0);
    do_op(8'd77, 8'd0, 1'b0, 1'b0);
    check("acc_zero_operands", 32'(acc), 32'd24);

    do_clear();
    do_op(8'd5, 8'd10, 1'b0, 1'b0);
    check("acc_50", 32'(acc), 32'd50);
    in_valid = 1'b1;
    a = 8'd10;
    b = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_acc", 32'(acc), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    m_ovf = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_acc", 32'(acc), 32'd0);
    do_op(8'd2, 8'd3, 1'b0, 1'b0);
    check("acc_after_rst_op", 32'(acc), 32'd6);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
